// File: rtl/output_decoder_pkg.sv
// Shared types for the output strobe decoder: request modes and FSM states.
package output_decoder_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_PULSE  = 2'd1,
    MODE_THERMO = 2'd2,
    MODE_TOGGLE = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } state_e;
endpackage

// File: rtl/out_index_decode.sv
// Combinational decode of a 1-based select code into one-hot and thermometer vectors.
module out_index_decode #(
  parameter int IN_SIZE  = 3,
  parameter int OUT_SIZE = 8
) (
  input  logic [IN_SIZE-1:0]  sel,
  output logic [OUT_SIZE-1:0] onehot,
  output logic [OUT_SIZE-1:0] thermo,
  output logic                in_range
);
  assign in_range = (int'(sel) <= OUT_SIZE);

  // Code 0 matches no lane, so both vectors fall to zero naturally.
  for (genvar i = 0; i < OUT_SIZE; i++) begin : g_lane
    assign onehot[i] = (int'(sel) == i + 1);
    assign thermo[i] = in_range && (int'(sel) > i);
  end
endmodule

// File: rtl/output_strobe_decoder.sv
// Registered strobe decoder: hold / pulse / thermometer / toggle output modes
// with a sticky out-of-range flag and a fixed-length pulse FSM.
module output_strobe_decoder
  import output_decoder_pkg::*;
#(
  parameter int IN_SIZE   = 3,
  parameter int OUT_SIZE  = 8,
  parameter int PULSE_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_SIZE-1:0]  sel_i,
  input  logic [1:0]          mode_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic                clr_i,
  output logic [OUT_SIZE-1:0] out_o,
  output logic                busy_o,
  output logic                err_o
);
  localparam int CW = $clog2(PULSE_LEN + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [OUT_SIZE-1:0] out_q, out_d;
  logic                err_q, err_d;

  logic [OUT_SIZE-1:0] onehot, thermo;
  logic                in_range, accept;

  out_index_decode #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE)) u_dec (
    .sel      (sel_i),
    .onehot   (onehot),
    .thermo   (thermo),
    .in_range (in_range)
  );

  assign busy_o  = (state_q == ST_PULSE);
  assign ready_o = !busy_o;
  assign accept  = valid_i && ready_o;
  assign out_o   = out_q;
  assign err_o   = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    if (clr_i) begin
      // Clear wins over any same-cycle accept; the request is dropped.
      state_d = ST_IDLE;
      cnt_d   = '0;
      out_d   = '0;
      err_d   = 1'b0;
    end else if (state_q == ST_PULSE) begin
      // Counter starts at 1 on entry, so PULSE_LEN busy cycles end here.
      if (cnt_q == CW'(PULSE_LEN)) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        out_d   = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (accept) begin
      if (!in_range) begin
        err_d = 1'b1;
        out_d = '0;
      end else begin
        case (mode_e'(mode_i))
          MODE_HOLD:   out_d = onehot;
          MODE_THERMO: out_d = thermo;
          MODE_TOGGLE: out_d = out_q ^ onehot;
          MODE_PULSE: begin
            out_d = onehot;
            if (|sel_i) begin
              state_d = ST_PULSE;
              cnt_d   = CW'(1);
            end
          end
          default:     out_d = out_q;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_output_strobe_decoder.sv
// Directed plus randomized check of output_strobe_decoder against a cycle-level model.
module tb_output_strobe_decoder;
  localparam int IN_SIZE = 3, OUT_SIZE = 6, PULSE_LEN = 3;
  localparam int HOLD = 0, PULSE = 1, THERMO = 2, TOGGLE = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [IN_SIZE-1:0]  sel_i;
  logic [1:0]          mode_i;
  logic                valid_i, clr_i;
  logic                ready_o, busy_o, err_o;
  logic [OUT_SIZE-1:0] out_o;

  int ncmp = 0;
  int nerr = 0;

  // Reference model: output word, sticky error, remaining pulse cycles.
  int m_out, m_err, m_left;

  output_strobe_decoder #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .PULSE_LEN(PULSE_LEN)) dut (
    .clk(clk), .rst(rst), .sel_i(sel_i), .mode_i(mode_i), .valid_i(valid_i),
    .ready_o(ready_o), .clr_i(clr_i), .out_o(out_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_err = 0; m_left = 0;
  endtask

  task automatic model_clk(input logic v, input int s, input int md, input logic c);
    int bit_k;
    bit_k = (s == 0) ? 0 : (1 << (s - 1));
    if (c) begin
      m_out = 0; m_err = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_out = 0;
    end else if (v) begin
      if (s > OUT_SIZE) begin
        m_err = 1; m_out = 0;
      end else begin
        case (md)
          HOLD:    m_out = bit_k;
          THERMO:  m_out = (1 << s) - 1;
          TOGGLE:  m_out = m_out ^ bit_k;
          default: begin m_out = bit_k; m_left = (s == 0) ? 0 : PULSE_LEN; end
        endcase
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".out"},   32'(out_o),   32'(m_out));
    chk({tag, ".err"},   32'(err_o),   32'(m_err));
    chk({tag, ".busy"},  32'(busy_o),  32'(m_left > 0));
    chk({tag, ".ready"}, 32'(ready_o), 32'(m_left == 0));
  endtask

  // Drive at the falling edge, let one rising edge happen, check at the next fall.
  task automatic step(input logic v, input int s, input int md, input logic c, input string tag);
    valid_i = v; sel_i = s[IN_SIZE-1:0]; mode_i = md[1:0]; clr_i = c;
    @(posedge clk);
    model_clk(v, s, md, c);
    @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    rst = 1'b1; valid_i = 1'b0; sel_i = '0; mode_i = '0; clr_i = 1'b0;
    model_reset();
    #3;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    // One-hot hold, kept for ten idle cycles, then code 0
    step(1, 3, HOLD, 0, "hold3");
    chk("hold3.const", 32'(out_o), 32'h04);
    repeat (10) step(0, 0, HOLD, 0, "hold_keep");
    step(1, 0, HOLD, 0, "hold0");
    chk("hold0.const", 32'(out_o), 32'h00);

    // Pulse of exactly three cycles; requests during it are ignored
    step(1, 6, PULSE, 0, "pulse6");
    chk("pulse6.const", 32'(out_o), 32'h20);
    chk("pulse6.busy",  32'(busy_o), 32'h1);
    step(1, 1, HOLD, 0, "pulse_ign1");
    step(1, 2, THERMO, 0, "pulse_ign2");
    step(1, 1, HOLD, 0, "pulse_end");
    chk("pulse_end.const", 32'(out_o), 32'h00);
    chk("pulse_end.ready", 32'(ready_o), 32'h1);

    // Thermometer and toggle
    step(1, 4, THERMO, 0, "thermo4");
    chk("thermo4.const", 32'(out_o), 32'h0f);
    step(0, 0, HOLD, 1, "clr0");
    step(1, 2, TOGGLE, 0, "toggle_a");
    chk("toggle_a.const", 32'(out_o), 32'h02);
    step(1, 2, TOGGLE, 0, "toggle_b");
    chk("toggle_b.const", 32'(out_o), 32'h00);
    step(1, 0, TOGGLE, 0, "toggle0");

    // Sticky error, surviving a legal accept, cleared by clr_i
    step(1, 7, HOLD, 0, "err7");
    chk("err7.const", 32'(err_o), 32'h1);
    step(1, 1, HOLD, 0, "err_keep");
    chk("err_keep.const", 32'(out_o), 32'h01);
    step(1, 7, PULSE, 0, "err_pulse");
    step(0, 0, HOLD, 1, "err_clr");
    chk("err_clr.const", 32'(err_o), 32'h0);

    // Asynchronous reset in the second pulse cycle
    step(1, 2, PULSE, 0, "pulse2");
    step(0, 0, HOLD, 0, "pulse2_c2");
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst.out",   32'(out_o),   32'h0);
    chk("async_rst.busy",  32'(busy_o),  32'h0);
    chk("async_rst.ready", 32'(ready_o), 32'h1);
    @(negedge clk);
    check_model("rst_held");
    rst = 1'b0;
    step(1, 3, THERMO, 0, "first_accept");
    chk("first_accept.const", 32'(out_o), 32'h07);
    step(1, 5, HOLD, 1, "clr_wins");
    chk("clr_wins.const", 32'(out_o), 32'h00);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
